cnt_seq_ctrl: RTL and testbench

//  Run-control sequencer for the binary counter datapath. Makes a programmable tick

---
 rtl/cnt_seq_pkg.sv | 20 ++
 rtl/cnt_tick_gen.sv | 37 +++
 rtl/cnt_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared encodings and defaults for the counter run-control sequencer.
// Pure declarations: no logic, no latency, no flow control.
// Backpressure: not applicable.
package cnt_seq_pkg;

   localparam int CNT_W_DEF = 4;
   localparam int DIV_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/cnt_tick_gen.sv
// Programmable tick divider: counts 0..div_max_i while enabled, then wraps.
// Latency: tick_o is combinational from the divider register (due this cycle).
// Backpressure: en_i low freezes the phase; clr_i restarts it and wins over en_i.
module cnt_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] div_max_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   assign tick_o = (div_q == div_max_i);

   always_comb begin
      div_d = div_q;
      if (clr_i) begin
         div_d = '0;
      end else if (en_i) begin
         div_d = tick_o ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run-control sequencer: start/stop/pause FSM stepping a counter on divided ticks.
// Latency: all outputs registered; first tick cfg_div+1 cycles after accepted start.
// Backpressure: none; commands are level-sampled, priority stop > pause > start.
// Optional down-counting via CNT_SEQ_CTRL_DOWN_EN (adds cfg_down input).
module cnt_seq_ctrl
   import cnt_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_load,
   input  logic [CNT_W-1:0] cfg_term,
   input  logic             cfg_oneshot,
`ifdef CNT_SEQ_CTRL_DOWN_EN
   input  logic             cfg_down,
`endif
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             wrap,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [DIV_W-1:0] div_sh_q;
   logic [CNT_W-1:0] term_sh_q;
   logic [CNT_W-1:0] load_sh_q;
   logic             one_sh_q;
`ifdef CNT_SEQ_CTRL_DOWN_EN
   logic             down_sh_q;
`endif

   logic             start_ok;
   logic             load_cfg;
   logic             run_go;
   logic             due;
   logic             step;
   logic             at_term;
   logic [CNT_W-1:0] cnt_nxt;

   // pause outranks start even where pause itself has no effect
   assign start_ok = start && !stop && !pause;
   assign load_cfg = start_ok && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign run_go   = (state_q == ST_RUN) && !stop && !pause;
   assign step     = run_go && due;
   assign at_term  = (cnt_q == term_sh_q);

`ifdef CNT_SEQ_CTRL_DOWN_EN
   assign cnt_nxt = down_sh_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
`else
   assign cnt_nxt = cnt_q + 1'b1;
`endif

   cnt_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .en_i      (run_go),
      .clr_i     (stop || load_cfg),
      .div_max_i (div_sh_q),
      .tick_o    (due)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start_ok) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (due && at_term && one_sh_q) begin
               state_d = ST_DONE;
            end
         end
         ST_PAUSE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start_ok) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      done_d = 1'b0;
      if (load_cfg) begin
         cnt_d = cfg_load;
      end else if (step) begin
         tick_d = 1'b1;
         if (at_term) begin
            if (one_sh_q) begin
               done_d = 1'b1;
            end else begin
               cnt_d  = load_sh_q;
               wrap_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_nxt;
         end
      end
      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         div_sh_q  <= '0;
         term_sh_q <= '0;
         load_sh_q <= '0;
         one_sh_q  <= 1'b0;
`ifdef CNT_SEQ_CTRL_DOWN_EN
         down_sh_q <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
         done_q <= done_d;
         busy_q <= busy_d;
         if (load_cfg) begin
            div_sh_q  <= cfg_div;
            term_sh_q <= cfg_term;
            load_sh_q <= cfg_load;
            one_sh_q  <= cfg_oneshot;
`ifdef CNT_SEQ_CTRL_DOWN_EN
            down_sh_q <= cfg_down;
`endif
         end
      end
   end

   assign cnt   = cnt_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign state = state_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed scenarios plus randomized run
// against a cycle-level reference model; honours CNT_SEQ_CTRL_DOWN_EN.
module tb_cnt_seq_ctrl;

   localparam int CNT_W = 4;
   localparam int DIV_W = 16;
   localparam int MOD   = 1 << CNT_W;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

   logic             clk = 1'b0;
   logic             rst, start, stop, pause, cfg_oneshot;
   logic [DIV_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_load, cfg_term;
`ifdef CNT_SEQ_CTRL_DOWN_EN
   logic             cfg_down;
`endif
   logic [CNT_W-1:0] cnt;
   logic             tick, wrap, done, busy;
   logic [1:0]       state;

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_state, m_cnt, m_phase, m_div, m_term, m_load, m_one, m_down;
   int m_tick, m_wrap, m_done, m_busy;

   always #5 clk = ~clk;

   cnt_seq_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .cfg_div     (cfg_div),
      .cfg_load    (cfg_load),
      .cfg_term    (cfg_term),
      .cfg_oneshot (cfg_oneshot),
`ifdef CNT_SEQ_CTRL_DOWN_EN
      .cfg_down    (cfg_down),
`endif
      .cnt         (cnt),
      .tick        (tick),
      .wrap        (wrap),
      .done        (done),
      .busy        (busy),
      .state       (state)
   );

   task automatic model_edge();
      if (!rst) begin
         m_state = S_IDLE; m_cnt = 0; m_phase = 0; m_div = 0; m_term = 0;
         m_load = 0; m_one = 0; m_down = 0;
         m_tick = 0; m_wrap = 0; m_done = 0; m_busy = 0;
         return;
      end
      m_tick = 0; m_wrap = 0; m_done = 0;
      if (stop) begin
         m_state = S_IDLE;
         m_phase = 0;
      end else if ((m_state == S_IDLE || m_state == S_DONE) && start && !pause) begin
         m_div = int'(cfg_div); m_term = int'(cfg_term); m_load = int'(cfg_load);
         m_one = int'(cfg_oneshot);
`ifdef CNT_SEQ_CTRL_DOWN_EN
         m_down = int'(cfg_down);
`else
         m_down = 0;
`endif
         m_cnt = int'(cfg_load);
         m_phase = 0;
         m_state = S_RUN;
      end else if (m_state == S_RUN) begin
         if (pause) begin
            m_state = S_PAUSE;
         end else if (m_phase < m_div) begin
            m_phase++;
         end else begin
            m_phase = 0;
            m_tick = 1;
            if (m_cnt == m_term && m_one == 1) begin
               m_state = S_DONE;
               m_done = 1;
            end else if (m_cnt == m_term) begin
               m_cnt = m_load;
               m_wrap = 1;
            end else begin
               m_cnt = m_down ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
            end
         end
      end else if (m_state == S_PAUSE && start && !pause) begin
         m_state = S_RUN;
      end
      m_busy = (m_state == S_RUN || m_state == S_PAUSE) ? 1 : 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic go_idle();
      start = 0; pause = 0; stop = 1;
      step();
      stop = 0;
   endtask

   task automatic test_reset();
      rst = 0; start = 0; stop = 0; pause = 0;
      cfg_div = '0; cfg_load = '0; cfg_term = '0; cfg_oneshot = 0;
`ifdef CNT_SEQ_CTRL_DOWN_EN
      cfg_down = 0;
`endif
      step(); step();
      rst = 1;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      checks++; if ({tick, wrap, done, busy} !== 4'b0) begin failures++; $display("FAIL reset_outs: got %b want 0000", {tick, wrap, done, busy}); end
      // reset in the middle of a run
      cfg_div = 16'd1; cfg_load = 4'd7; cfg_term = 4'd12; cfg_oneshot = 0;
      start = 1; step(); start = 0;
      repeat (5) step();
      checks++; if (busy !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL midrun_busy: got busy=%b state=%0d want 1/1", busy, state); end
      rst = 0; step(); step(); rst = 1;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL midrun_rst_state: got %0d want 0", state); end
      checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL midrun_rst_cnt: got %0d want 0", cnt); end
      checks++; if ({tick, wrap, done, busy} !== 4'b0) begin failures++; $display("FAIL midrun_rst_outs: got %b want 0000", {tick, wrap, done, busy}); end
      step();
      checks++; if ({state, tick, wrap, done, busy} !== 6'b0) begin failures++; $display("FAIL post_rst_idle: got %b want 000000", {state, tick, wrap, done, busy}); end
   endtask

   task automatic test_oneshot();
      int ticks = 0;
      int bad_tick = 0;
      int done_at = -1;
      int bad_cnt = 0;
      go_idle();
      cfg_div = 16'd3; cfg_load = 4'd2; cfg_term = 4'd5; cfg_oneshot = 1;
      start = 1; step(); start = 0;
      checks++; if (cnt !== 4'd2 || state !== 2'd1) begin failures++; $display("FAIL oneshot_start: got cnt=%0d state=%0d want 2/1", cnt, state); end
      for (int c = 1; c <= 24; c++) begin
         step();
         if (tick === 1'b1) begin
            ticks++;
            if (c % 4 != 0) bad_tick++;
         end
         if (done === 1'b1) done_at = c;
         if (int'(cnt) != m_cnt) bad_cnt++;
      end
      checks++; if (ticks != 4 || bad_tick != 0) begin failures++; $display("FAIL oneshot_ticks: got %0d (%0d off-phase) want 4 (0)", ticks, bad_tick); end
      checks++; if (done_at != 16) begin failures++; $display("FAIL oneshot_done_cycle: got %0d want 16", done_at); end
      checks++; if (bad_cnt != 0) begin failures++; $display("FAIL oneshot_cnt_seq: %0d cycles differ from model, want 0", bad_cnt); end
      checks++; if (state !== 2'd3 || cnt !== 4'd5 || busy !== 1'b0) begin failures++; $display("FAIL oneshot_final: got state=%0d cnt=%0d busy=%b want 3/5/0", state, cnt, busy); end
   endtask

   task automatic test_periodic();
      int exp_c[8] = '{15, 0, 1, 14, 15, 0, 1, 14};
      go_idle();
      cfg_div = 16'd0; cfg_load = 4'd14; cfg_term = 4'd1; cfg_oneshot = 0;
      start = 1; step(); start = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         checks++; if (int'(cnt) != exp_c[c-1] || tick !== 1'b1) begin failures++; $display("FAIL periodic_cnt[%0d]: got cnt=%0d tick=%b want %0d/1", c, cnt, tick, exp_c[c-1]); end
         checks++; if (wrap !== ((c % 4) == 0)) begin failures++; $display("FAIL periodic_wrap[%0d]: got %b want %b", c, wrap, (c % 4) == 0); end
      end
      stop = 1; step(); stop = 0;
      checks++; if (state !== 2'd0 || cnt !== 4'd14 || tick !== 1'b0) begin failures++; $display("FAIL periodic_stop: got state=%0d cnt=%0d tick=%b want 0/14/0", state, cnt, tick); end
   endtask

   task automatic test_pause();
      logic [CNT_W-1:0] held;
      int bad = 0;
      int lat = -1;
      go_idle();
      cfg_div = 16'd9; cfg_load = 4'd0; cfg_term = 4'd15; cfg_oneshot = 1;
      start = 1; step(); start = 0;
      repeat (5) step();
      pause = 1; step(); pause = 0;
      held = cnt;
      checks++; if (state !== 2'd2 || cnt !== 4'd0 || busy !== 1'b1) begin failures++; $display("FAIL pause_enter: got state=%0d cnt=%0d busy=%b want 2/0/1", state, cnt, busy); end
      cfg_div = 16'd1;
      repeat (20) begin
         step();
         if (cnt !== held || tick !== 1'b0 || state !== 2'd2) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL pause_hold: %0d cycles moved, want 0", bad); end
      start = 1; step(); start = 0;
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL pause_resume: got state=%0d want 1", state); end
      for (int i = 1; i <= 30; i++) begin
         step();
         if (tick === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat != 5) begin failures++; $display("FAIL pause_phase: first tick after %0d cycles, want 5", lat); end
      checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL pause_step: got cnt=%0d want 1", cnt); end
   endtask

   task automatic test_collision();
      go_idle();
      cfg_div = 16'd2; cfg_load = 4'd3; cfg_term = 4'd10; cfg_oneshot = 0;
      start = 1; step(); start = 0;
      step(); step();
      stop = 1; pause = 1; start = 1; step();
      stop = 0; pause = 0; start = 0;
      checks++; if (state !== 2'd0 || tick !== 1'b0 || cnt !== 4'd3 || busy !== 1'b0) begin failures++; $display("FAIL stop_vs_tick: got state=%0d tick=%b cnt=%0d busy=%b want 0/0/3/0", state, tick, cnt, busy); end
      start = 1; step(); start = 0;
      step(); step();
      pause = 1; step(); pause = 0;
      checks++; if (state !== 2'd2 || tick !== 1'b0 || cnt !== 4'd3) begin failures++; $display("FAIL pause_vs_tick: got state=%0d tick=%b cnt=%0d want 2/0/3", state, tick, cnt); end
      start = 1; step(); start = 0;
      checks++; if (state !== 2'd1 || tick !== 1'b0) begin failures++; $display("FAIL held_due_resume: got state=%0d tick=%b want 1/0", state, tick); end
      step();
      checks++; if (tick !== 1'b1 || cnt !== 4'd4) begin failures++; $display("FAIL held_due_tick: got tick=%b cnt=%0d want 1/4", tick, cnt); end
   endtask

`ifdef CNT_SEQ_CTRL_DOWN_EN
   task automatic test_down();
      int exp_c[3] = '{0, 15, 14};
      go_idle();
      cfg_div = 16'd0; cfg_load = 4'd1; cfg_term = 4'd14; cfg_oneshot = 1; cfg_down = 1;
      start = 1; step(); start = 0;
      cfg_down = 0;
      checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL down_load: got %0d want 1", cnt); end
      for (int c = 1; c <= 3; c++) begin
         step();
         checks++; if (int'(cnt) != exp_c[c-1] || done !== 1'b0) begin failures++; $display("FAIL down_cnt[%0d]: got cnt=%0d done=%b want %0d/0", c, cnt, done, exp_c[c-1]); end
      end
      step();
      checks++; if (done !== 1'b1 || state !== 2'd3 || cnt !== 4'd14) begin failures++; $display("FAIL down_done: got done=%b state=%0d cnt=%0d want 1/3/14", done, state, cnt); end
   endtask
`endif

   task automatic test_random();
      int shown = 0;
      go_idle();
      for (int c = 0; c < 1500; c++) begin
         start = ($urandom_range(0, 99) < 10);
         stop  = ($urandom_range(0, 99) < 3);
         pause = ($urandom_range(0, 99) < 6);
         rst   = ($urandom_range(0, 299) != 0);
         cfg_div     = 16'($urandom_range(0, 3));
         cfg_load    = 4'($urandom_range(0, 15));
         cfg_term    = 4'($urandom_range(0, 15));
         cfg_oneshot = 1'($urandom_range(0, 1));
`ifdef CNT_SEQ_CTRL_DOWN_EN
         cfg_down    = 1'($urandom_range(0, 1));
`endif
         step();
         checks++;
         if (int'(state) != m_state || int'(cnt) != m_cnt ||
             int'(tick) != m_tick || int'(wrap) != m_wrap ||
             int'(done) != m_done || int'(busy) != m_busy) begin
            failures++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random[%0d]: got st=%0d cnt=%0d t/w/d/b=%b%b%b%b want st=%0d cnt=%0d t/w/d/b=%0d%0d%0d%0d",
                        c, state, cnt, tick, wrap, done, busy, m_state, m_cnt, m_tick, m_wrap, m_done, m_busy);
            end
         end
      end
      rst = 1; start = 0; stop = 0; pause = 0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_pause();
      test_collision();
`ifdef CNT_SEQ_CTRL_DOWN_EN
      test_down();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
